ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Multi-cycle instruction fetch unit. It replaces the zero-latency combinational instruction memory path that sits upstream of the decoder/control unit.
- Owns the architectural fetch PC and issues one request at a time over a valid/ready memory interface that may take several cycles to respond.
- Buffers the returned instruction and holds it for the decoder with a valid/ready handshake.
- Waits for the execute/write-back commit, which supplies the next PC (sequential, JAL or JALR target), before fetching again.
- Detects fetch faults (bus error, response timeout, misaligned next PC) and stops fetching.

Parameters:
- RESET_PC, 32'h8000_0000, fetch address used after reset.
- TIMEOUT, 255, cycles in WAIT without a response before a timeout fault; legal range 1..65535.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = in reset).
- req_valid  out  1  memory request valid.
- req_ready  in  1  memory accepts the request.
- req_addr  out  32  fetch address, word aligned.
- rsp_valid  in  1  memory response valid.
- rsp_data  in  32  instruction word.
- rsp_err  in  1  bus error, qualified by rsp_valid.
- inst_valid  out  1  instruction available to the decoder.
- inst_ready  in  1  decoder accepts the instruction.
- inst  out  32  buffered instruction.
- inst_pc  out  32  PC of inst.
- commit_valid  in  1  current instruction retired.
- commit_next_pc  in  32  next PC from the PC/branch logic.
- fault  out  1  sticky fetch fault.
- fault_cause  out  2  1 = bus error, 2 = timeout, 3 = misaligned next PC.
- fault_pc  out  32  address that faulted.
- fetch_count  out  32  number of instructions handed to the decoder.

Behaviour:
- States: IDLE, FETCH, WAIT, VALID, EXEC, FAULT. All state and outputs are registered or decoded only from registered state.
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=RESET_PC.
  - req_valid=0, inst_valid=0, fault=0, fault_cause=0, fault_pc=0, inst=0, fetch_count=0, timeout counter=0.
  - Reset asserted in any state aborts the operation immediately. The memory side shares this reset, so no stale response can arrive afterwards.
- IDLE: move to FETCH on the first clock edge after reset is released.
- FETCH:
  - req_valid=1, req_addr=pc.
  - req_valid and req_addr stay stable until req_ready=1.
  - On req_ready, go to WAIT and clear the timeout counter.
  - rsp_valid is ignored in this state.
- WAIT:
  - req_valid=0. A response is accepted unconditionally.
  - rsp_valid with rsp_err=1: go to FAULT, cause=1, fault_pc=pc.
  - rsp_valid with rsp_err=0: inst<=rsp_data, inst_pc<=pc, go to VALID.
  - Otherwise the counter increments. When the counter reaches TIMEOUT-1 without a response, go to FAULT with cause=2.
  - If rsp_valid arrives in the same cycle as the timeout, the response wins.
- VALID:
  - inst_valid=1; inst and inst_pc are stable.
  - On inst_ready, fetch_count increments (wraps 0xFFFF_FFFF to 0) and the state goes to EXEC.
- EXEC:
  - inst_valid=0. Wait for commit_valid.
  - On commit_valid, pc<=commit_next_pc.
  - If commit_next_pc[1:0]!=0: go to FAULT, cause=3, fault_pc=commit_next_pc.
  - Otherwise go to FETCH.
- commit_valid is ignored in every state other than EXEC.
- FAULT:
  - fault=1; cause and fault_pc are held.
  - No requests are issued, inst_valid=0. The state is sticky until reset.
- Latency:
  - Commit in cycle N gives FETCH in N+1.
  - With req_ready=1 in N+1 and a one-cycle memory, rsp_valid arrives in N+2 and inst_valid=1 in N+3.
  - From the first edge after reset release, req_valid=1 in cycle 1.
- Widths: pc and addresses are 32 bits with no arithmetic on them. The next PC is supplied externally.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, FETCH, WAIT, VALID, EXEC, FAULT);
  - fault cause constants FC_NONE=0, FC_BUSERR=1, FC_TIMEOUT=2, FC_MISALIGN=3;
  - the RESET_PC default 32'h8000_0000.
- One sub-module, ifu_timeout: a clearable up-counter with an expiry flag, parameterised by TIMEOUT.

Test Plan:
- Reset with req_ready=1 and a one-cycle memory returning 32'h0010_0093 -> req_addr=32'h8000_0000 in cycle 1; inst_valid=1, inst=32'h0010_0093, inst_pc=32'h8000_0000 in cycle 3.
- Hold inst_ready=0 for 5 cycles, then 1; commit with next_pc=32'h8000_0004 -> inst stays stable throughout; fetch_count=1; next req_addr=32'h8000_0004.
- Drive req_ready low for 3 cycles in FETCH -> req_valid=1 and req_addr unchanged until acceptance; exactly one request issued.
- Response with rsp_err=1 -> fault=1, fault_cause=1, fault_pc=request address; no further req_valid; commit_valid pulses ignored.
- TIMEOUT=4, no response -> fault_cause=2 on the 4th WAIT cycle. Repeat with rsp_valid on that same cycle -> no fault; VALID entered.
- commit_next_pc=32'h8000_0006 -> fault_cause=3, fault_pc=32'h8000_0006. Assert rst=0 mid-WAIT in a separate run -> all outputs return to reset values asynchronously; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned FC_W  = 2;
    localparam int unsigned TMO_W = 16;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        EXEC  = 3'd4,
        FAULT = 3'd5
    } ifu_state_e;

    localparam logic [FC_W-1:0] FC_NONE     = 2'd0;
    localparam logic [FC_W-1:0] FC_BUSERR   = 2'd1;
    localparam logic [FC_W-1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [FC_W-1:0] FC_MISALIGN = 2'd3;

    typedef struct packed {
        logic [FC_W-1:0] cause;
        logic [XLEN-1:0] pc;
    } fault_info_t;

    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_timeout.sv
// Clearable response-wait counter; flags expiry once TIMEOUT-1 is reached.
module ifu_timeout
    import ifu_fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired_c
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] r_cnt;

    // Holds at the terminal value so the flag cannot wrap away.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_expired_c) begin
            r_cnt <= r_cnt + TMO_W'(1);
        end
    end

    assign o_expired_c = (r_cnt == LAST);

endmodule

// File: rtl/ifu_fetch.sv
// Multi-cycle instruction fetch: one outstanding memory request, buffered
// instruction to the decoder, next PC supplied by commit, sticky faults.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned     TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    input  logic            rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_next_pc,
    output logic            fault,
    output logic [FC_W-1:0] fault_cause,
    output logic [XLEN-1:0] fault_pc,
    output logic [XLEN-1:0] fetch_count
);

    ifu_state_e      r_state;
    ifu_state_e      w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic [XLEN-1:0] r_fetch_count;
    logic            r_req_valid;
    logic            r_inst_valid;
    logic            r_fault;
    fault_info_t     r_fault_info;
    fault_info_t     w_fault_nxt;
    logic            w_tmo_clr;
    logic            w_tmo_inc;
    logic            w_tmo_expired;
    logic            w_load_fault;
    logic            w_load_inst;
    logic            w_load_pc;
    logic            w_accept;

    ifu_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk       (clk),
        .i_rst_n     (rst),
        .i_clr       (w_tmo_clr),
        .i_inc       (w_tmo_inc),
        .o_expired_c (w_tmo_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A response in the expiry cycle takes priority over the timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_tmo_clr    = 1'b0;
        w_tmo_inc    = 1'b0;
        w_load_fault = 1'b0;
        w_load_inst  = 1'b0;
        w_load_pc    = 1'b0;
        w_accept     = 1'b0;
        w_fault_nxt  = '{cause: FC_NONE, pc: r_pc};
        unique case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
            end
            FETCH: begin
                if (req_ready) begin
                    w_state_nxt = WAIT;
                    w_tmo_clr   = 1'b1;
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    if (rsp_err) begin
                        w_state_nxt       = FAULT;
                        w_load_fault      = 1'b1;
                        w_fault_nxt.cause = FC_BUSERR;
                    end else begin
                        w_state_nxt = VALID;
                        w_load_inst = 1'b1;
                    end
                end else if (w_tmo_expired) begin
                    w_state_nxt       = FAULT;
                    w_load_fault      = 1'b1;
                    w_fault_nxt.cause = FC_TIMEOUT;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            VALID: begin
                if (inst_ready) begin
                    w_state_nxt = EXEC;
                    w_accept    = 1'b1;
                end
            end
            EXEC: begin
                if (commit_valid) begin
                    w_load_pc = 1'b1;
                    if (is_misaligned(commit_next_pc[1:0])) begin
                        w_state_nxt  = FAULT;
                        w_load_fault = 1'b1;
                        w_fault_nxt  = '{cause: FC_MISALIGN, pc: commit_next_pc};
                    end else begin
                        w_state_nxt = FETCH;
                    end
                end
            end
            FAULT: begin
                w_state_nxt = FAULT;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Handshake flags registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_valid  <= 1'b0;
            r_inst_valid <= 1'b0;
        end else begin
            r_req_valid  <= (w_state_nxt == FETCH);
            r_inst_valid <= (w_state_nxt == VALID);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_inst        <= '0;
            r_inst_pc     <= '0;
            r_fetch_count <= '0;
        end else begin
            if (w_load_pc) begin
                r_pc <= commit_next_pc;
            end
            if (w_load_inst) begin
                r_inst    <= rsp_data;
                r_inst_pc <= r_pc;
            end
            if (w_accept) begin
                r_fetch_count <= r_fetch_count + XLEN'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fault      <= 1'b0;
            r_fault_info <= '0;
        end else if (w_load_fault) begin
            r_fault      <= 1'b1;
            r_fault_info <= w_fault_nxt;
        end
    end

    assign req_valid   = r_req_valid;
    assign req_addr    = r_pc;
    assign inst_valid  = r_inst_valid;
    assign inst        = r_inst;
    assign inst_pc     = r_inst_pc;
    assign fault       = r_fault;
    assign fault_cause = r_fault_info.cause;
    assign fault_pc    = r_fault_info.pc;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed and randomized fetch transactions checked
// cycle by cycle against a transaction-level model of the fetch rules.
module tb_ifu_fetch;

    localparam int unsigned TMO = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        commit_valid;
    logic [31:0] commit_next_pc;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic [31:0] m_fpc;
    logic [1:0]  m_cause;
    bit          m_fault;

    ifu_fetch #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .commit_valid   (commit_valid),
        .commit_next_pc (commit_next_pc),
        .fault          (fault),
        .fault_cause    (fault_cause),
        .fault_pc       (fault_pc),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Commit traffic outside EXEC must have no effect.
    task automatic noise();
        commit_valid   = 1'($urandom);
        commit_next_pc = $urandom;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_err      = 1'b0;
        rsp_data     = '0;
        inst_ready   = 1'b0;
        commit_valid = 1'b0;
        #1;
        chk1 ("rst_req_valid",   req_valid,  1'b0);
        chk1 ("rst_inst_valid",  inst_valid, 1'b0);
        chk1 ("rst_fault",       fault,      1'b0);
        chk32("rst_fault_cause", 32'(fault_cause), 32'd0);
        chk32("rst_fault_pc",    fault_pc,    32'd0);
        chk32("rst_inst",        inst,        32'd0);
        chk32("rst_fetch_count", fetch_count, 32'd0);
        m_pc    = RST_PC;
        m_count = '0;
        m_fault = 1'b0;
        m_cause = 2'd0;
        m_fpc   = '0;
        tick();
        tick();
        rst = 1'b1;
        chk1("idle_req_valid", req_valid, 1'b0);
        tick();
        chk1 ("first_req_valid", req_valid, 1'b1);
        chk32("first_req_addr",  req_addr,  m_pc);
    endtask

    task automatic fault_hold();
        for (int j = 0; j < 3; j++) begin
            chk1 ("fault",            fault, 1'b1);
            chk32("fault_cause",      32'(fault_cause), 32'(m_cause));
            chk32("fault_pc",         fault_pc, m_fpc);
            chk1 ("fault_req_valid",  req_valid, 1'b0);
            chk1 ("fault_inst_valid", inst_valid, 1'b0);
            noise();
            req_ready = 1'($urandom);
            rsp_valid = 1'($urandom);
            tick();
        end
        commit_valid = 1'b0;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
    endtask

    // One fetch transaction starting in a FETCH cycle. rsp_lat is the WAIT
    // cycle (1-based) carrying the response; 0 means memory never answers.
    task automatic do_fetch(input int req_delay, input int rsp_lat, input bit err,
                            input logic [31:0] data, input int ready_delay,
                            input int commit_delay, input logic [31:0] next_pc);
        int  outcome;
        bit  done;
        outcome = 2;
        done    = 1'b0;
        for (int i = 0; i < req_delay; i++) begin
            req_ready = 1'b0;
            noise();
            rsp_valid = 1'($urandom);
            rsp_err   = 1'($urandom);
            rsp_data  = $urandom;
            chk1 ("req_valid_hold", req_valid, 1'b1);
            chk32("req_addr_hold",  req_addr,  m_pc);
            tick();
        end
        chk1 ("req_valid",        req_valid,  1'b1);
        chk32("req_addr",         req_addr,   m_pc);
        chk1 ("fetch_inst_valid", inst_valid, 1'b0);
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        for (int k = 1; k <= int'(TMO) && !done; k++) begin
            chk1("wait_req_valid",  req_valid,  1'b0);
            chk1("wait_inst_valid", inst_valid, 1'b0);
            chk1("wait_fault",      fault,      1'b0);
            noise();
            if (k == rsp_lat) begin
                rsp_valid = 1'b1;
                rsp_err   = err;
                rsp_data  = data;
                outcome   = err ? 1 : 0;
                done      = 1'b1;
            end
            tick();
            rsp_valid = 1'b0;
            rsp_err   = 1'b0;
        end
        if (outcome != 0) begin
            m_fault = 1'b1;
            m_cause = (outcome == 1) ? 2'd1 : 2'd2;
            m_fpc   = m_pc;
            fault_hold();
            return;
        end
        for (int j = 0; j <= ready_delay; j++) begin
            chk1 ("inst_valid",   inst_valid, 1'b1);
            chk32("inst",         inst,       data);
            chk32("inst_pc",      inst_pc,    m_pc);
            chk32("count_valid",  fetch_count, m_count);
            chk1 ("valid_req",    req_valid,  1'b0);
            inst_ready = (j == ready_delay);
            noise();
            tick();
        end
        inst_ready   = 1'b0;
        commit_valid = 1'b0;
        m_count      = m_count + 32'd1;
        for (int j = 0; j <= commit_delay; j++) begin
            chk1 ("exec_inst_valid", inst_valid,  1'b0);
            chk1 ("exec_req_valid",  req_valid,   1'b0);
            chk32("count_exec",      fetch_count, m_count);
            if (j == commit_delay) begin
                commit_valid   = 1'b1;
                commit_next_pc = next_pc;
            end
            tick();
        end
        commit_valid = 1'b0;
        m_pc = next_pc;
        if (next_pc[1:0] != 2'b00) begin
            m_fault = 1'b1;
            m_cause = 2'd3;
            m_fpc   = next_pc;
            fault_hold();
        end else begin
            chk1 ("next_req_valid", req_valid, 1'b1);
            chk32("next_req_addr",  req_addr,  next_pc);
            chk1 ("next_fault",     fault,     1'b0);
        end
    endtask

    initial begin
        logic [31:0] np;
        int          r;
        int          lat;
        bit          e;
        commit_next_pc = '0;
        do_reset();
        do_fetch(0, 1, 1'b0, 32'h0010_0093, 5, 0, 32'h8000_0004);
        do_fetch(3, 2, 1'b0, 32'hCAFE_0013, 0, 1, 32'h8000_0008);
        do_fetch(0, int'(TMO), 1'b0, 32'h1234_5678, 1, 2, 32'h8000_0100);
        do_fetch(0, 0, 1'b0, 32'h0, 0, 0, 32'h0);
        do_reset();
        do_fetch(1, 2, 1'b1, 32'hDEAD_BEEF, 0, 0, 32'h0);
        do_reset();
        do_fetch(0, 1, 1'b0, 32'h0000_0013, 0, 0, 32'h8000_0006);
        do_reset();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        tick();
        do_reset();
        do_fetch(0, 1, 1'b0, 32'h0040_0113, 0, 0, 32'h8000_0004);
        for (int t = 0; t < 40; t++) begin
            if (m_fault) do_reset();
            r   = int'($urandom_range(0, 11));
            lat = (r < 10) ? 1 + (r % int'(TMO)) : 0;
            e   = ($urandom_range(0, 15) == 0);
            np  = $urandom;
            if ($urandom_range(0, 9) != 0) np[1:0] = 2'b00;
            else                           np[1:0] = 2'($urandom_range(1, 3));
            do_fetch(int'($urandom_range(0, 3)), lat, e, $urandom,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), np);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
